// File: rtl/scan_decoder14_pkg.sv
// Shared constants for the 14-segment scan decoder: glyph patterns,
// glyph codes and the capture FSM state type.
package scan_dec_pkg;

   localparam int NUM_DIGITS = 12;
   localparam logic [3:0] LAST_POS = 4'd11;

   localparam logic [13:0] GLYPH_SPACE = 14'b00000000000000;
   localparam logic [13:0] GLYPH_A     = 14'b11101111000000;
   localparam logic [13:0] GLYPH_E     = 14'b10011110000000;
   localparam logic [13:0] GLYPH_I     = 14'b10010000010010;
   localparam logic [13:0] GLYPH_L     = 14'b00011100000000;
   localparam logic [13:0] GLYPH_O     = 14'b11111100000000;
   localparam logic [13:0] GLYPH_R     = 14'b11001111000100;
   localparam logic [13:0] GLYPH_S     = 14'b10110111000000;

   localparam logic [5:0] CODE_SPACE   = 6'd0;
   localparam logic [5:0] CODE_A       = 6'd1;
   localparam logic [5:0] CODE_E       = 6'd5;
   localparam logic [5:0] CODE_I       = 6'd9;
   localparam logic [5:0] CODE_L       = 6'd12;
   localparam logic [5:0] CODE_O       = 6'd15;
   localparam logic [5:0] CODE_R       = 6'd18;
   localparam logic [5:0] CODE_S       = 6'd19;
   localparam logic [5:0] CODE_UNKNOWN = 6'h3F;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CAPTURE = 2'd1,
      EMIT    = 2'd2
   } state_t;

endpackage

// File: rtl/scan_decoder14_if.sv
// Scan-side inputs, character output handshake and status pulses of the
// scan decoder; master drives the scan, slave is the decoder.
interface scan_decoder14_if;
   logic [11:0] sel;
   logic [13:0] segm;
   logic        out_ready;
   logic        out_valid;
   logic [5:0]  out_char;
   logic [3:0]  out_pos;
   logic        frame_done;
   logic        err_sel;
   logic        err_seq;
   logic        err_glyph;

   modport master (
      output sel, segm, out_ready,
      input  out_valid, out_char, out_pos, frame_done, err_sel, err_seq, err_glyph
   );

   modport slave (
      input  sel, segm, out_ready,
      output out_valid, out_char, out_pos, frame_done, err_sel, err_seq, err_glyph
   );
endinterface

// File: rtl/scan_glyph_lut.sv
// Combinational 14-segment pattern to glyph code map; unknown patterns
// return CODE_UNKNOWN with known low.
module scan_glyph_lut
   import scan_dec_pkg::*;
(
   input  logic [13:0] segm,
   output logic [5:0]  code,
   output logic        known
);

   always_comb begin
      code  = CODE_UNKNOWN;
      known = 1'b1;
      case (segm)
         GLYPH_SPACE: code = CODE_SPACE;
         GLYPH_A:     code = CODE_A;
         GLYPH_E:     code = CODE_E;
         GLYPH_I:     code = CODE_I;
         GLYPH_L:     code = CODE_L;
         GLYPH_O:     code = CODE_O;
         GLYPH_R:     code = CODE_R;
         GLYPH_S:     code = CODE_S;
         default:     known = 1'b0;
      endcase
   end

endmodule

// File: rtl/scan_decoder14.sv
// Captures one 12-digit frame from a multiplexed 14-segment scan and emits it
// as glyph codes over a valid/ready stream. Option: SCAN_DEC_GLYPH_ERR_EN.
//
// state   | meaning
// HUNT    | waiting for digit position 0 to start a frame
// CAPTURE | storing digits in order, watching for skips and stalls
// EMIT    | streaming buffer[0..11] to the consumer, scan inputs ignored
module scan_decoder14
   import scan_dec_pkg::*;
#(
   parameter int STALL_MAX = 16
) (
   input logic             clk,
   input logic             rst_n,
   scan_decoder14_if.slave bus
);

   localparam int CW = $clog2(STALL_MAX + 1);
   localparam logic [CW-1:0] STALL_LIM = CW'(STALL_MAX);

   state_t          state, state_nxt;
   logic [11:0]     sel_q;
   logic [13:0]     segm_q;
   logic [5:0]      buf_q   [NUM_DIGITS];
   logic [5:0]      buf_nxt [NUM_DIGITS];
   logic [3:0]      exp_q, exp_nxt, k_q, k_nxt;
   logic [CW-1:0]   stall_q, stall_nxt, stall_inc;
   logic            fd_q, fd_nxt, esel_q, esel_nxt, eseq_q, eseq_nxt, egl_q, egl_nxt;
   logic [5:0]      code;
   logic            known, glyph_bad, multi, hit;
   logic [3:0]      pos;

   scan_glyph_lut u_lut (.segm(segm_q), .code(code), .known(known));

`ifdef SCAN_DEC_GLYPH_ERR_EN
   assign glyph_bad = ~known;
`else
   assign glyph_bad = 1'b0 & ~known;
`endif

   always_comb begin
      pos = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (sel_q[i]) pos = 4'(i);
   end

   assign multi     = |(sel_q & (sel_q - 12'd1));
   assign hit       = (|sel_q) & ~multi;
   assign stall_inc = (stall_q == STALL_LIM) ? stall_q : stall_q + 1'b1;

   always_comb begin
      state_nxt = state;
      buf_nxt   = buf_q;
      exp_nxt   = exp_q;
      k_nxt     = k_q;
      stall_nxt = stall_q;
      fd_nxt    = 1'b0;
      esel_nxt  = 1'b0;
      eseq_nxt  = 1'b0;
      egl_nxt   = 1'b0;
      case (state)
         HUNT: begin
            stall_nxt = '0;
            if (multi) begin
               esel_nxt = 1'b1;
            end else if (hit && pos == 4'd0) begin
               if (glyph_bad) begin
                  egl_nxt = 1'b1;
               end else begin
                  buf_nxt[0] = code;
                  exp_nxt    = 4'd1;
                  state_nxt  = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (multi) begin
               esel_nxt  = 1'b1;
               state_nxt = HUNT;
               exp_nxt   = '0;
               stall_nxt = '0;
            end else if (hit && (pos == exp_q || pos == 4'd0 || pos == exp_q - 4'd1)) begin
               if (glyph_bad) begin
                  egl_nxt   = 1'b1;
                  state_nxt = HUNT;
                  exp_nxt   = '0;
                  stall_nxt = '0;
               end else if (pos == exp_q) begin
                  buf_nxt[pos] = code;
                  stall_nxt    = '0;
                  if (exp_q == LAST_POS) begin
                     state_nxt = EMIT;
                     exp_nxt   = '0;
                     k_nxt     = '0;
                  end else begin
                     exp_nxt = exp_q + 4'd1;
                  end
               end else if (pos == 4'd0) begin
                  buf_nxt[0] = code;
                  exp_nxt    = 4'd1;
                  stall_nxt  = '0;
               end else begin
                  // held digit: refresh the entry but it does not count as progress
                  buf_nxt[pos] = code;
                  stall_nxt    = stall_inc;
               end
            end else if (hit) begin
               eseq_nxt  = 1'b1;
               state_nxt = HUNT;
               exp_nxt   = '0;
               stall_nxt = '0;
            end else begin
               stall_nxt = stall_inc;
            end
            if (state_nxt == CAPTURE && stall_nxt == STALL_LIM) begin
               eseq_nxt  = 1'b1;
               state_nxt = HUNT;
               exp_nxt   = '0;
               stall_nxt = '0;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               if (k_q == LAST_POS) begin
                  fd_nxt    = 1'b1;
                  state_nxt = HUNT;
                  k_nxt     = '0;
               end else begin
                  k_nxt = k_q + 4'd1;
               end
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= HUNT;
         sel_q   <= '0;
         segm_q  <= '0;
         exp_q   <= '0;
         k_q     <= '0;
         stall_q <= '0;
         fd_q    <= 1'b0;
         esel_q  <= 1'b0;
         eseq_q  <= 1'b0;
         egl_q   <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= '0;
      end else begin
         state   <= state_nxt;
         sel_q   <= bus.sel;
         segm_q  <= bus.segm;
         exp_q   <= exp_nxt;
         k_q     <= k_nxt;
         stall_q <= stall_nxt;
         fd_q    <= fd_nxt;
         esel_q  <= esel_nxt;
         eseq_q  <= eseq_nxt;
         egl_q   <= egl_nxt;
         buf_q   <= buf_nxt;
      end
   end

   assign bus.out_valid  = (state == EMIT);
   assign bus.out_char   = (state == EMIT) ? buf_q[k_q] : 6'd0;
   assign bus.out_pos    = (state == EMIT) ? k_q : 4'd0;
   assign bus.frame_done = fd_q;
   assign bus.err_sel    = esel_q;
   assign bus.err_seq    = eseq_q;
   assign bus.err_glyph  = egl_q;

endmodule

// File: doc/scan_decoder14.md
SCAN_DECODER14 -- requirements
Module: scan_decoder14

Interface
REQ-001 SHALL have parameter STALL_MAX, default 16, the maximum number of cycles in CAPTURE without a new digit position before the frame is abandoned.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-004 SHALL have port sel, input, 12, the one-hot digit select from the 14-segment scan driver.
REQ-005 SHALL have port segm, input, 14, the segment pattern for the selected digit.
REQ-006 SHALL have port out_ready, input, 1, the consumer ready signal.
REQ-007 SHALL have port out_valid, output, 1, which marks the character output as valid.
REQ-008 SHALL have port out_char, output, 6, the decoded glyph code.
REQ-009 SHALL have port out_pos, output, 4, the digit position (0..11) of out_char.
REQ-010 SHALL have port frame_done, output, 1, a one-cycle pulse after position 11 transfers.
REQ-011 SHALL have port err_sel, output, 1, a one-cycle pulse when sel has more than one bit set.
REQ-012 SHALL have port err_seq, output, 1, a one-cycle pulse on an out-of-order position or a stall timeout.
REQ-013 SHALL have port err_glyph, output, 1, a one-cycle pulse on an unknown segment pattern.

Function
REQ-014 SHALL register sel and segm into an input stage each cycle, and all decode SHALL use the registered values (1-cycle input latency).
REQ-015 SHALL map the registered segm to a code. The patterns are:
- space 0 = 14'b00000000000000
- A 1 = 14'b11101111000000
- E 5 = 14'b10011110000000
- I 9 = 14'b10010000010010
- L 12 = 14'b00011100000000
- O 15 = 14'b11111100000000
- R 18 = 14'b11001111000100
- S 19 = 14'b10110111000000
- any other pattern = unknown, code 6'h3F.
REQ-016 SHALL take position as the index of the single set bit of registered sel. sel == 0 is blanking: ignored, no error, stall counter keeps counting.
REQ-017 SHALL implement the states HUNT, CAPTURE and EMIT.
REQ-018 In HUNT, SHALL go to CAPTURE when position 0 arrives, store its code in buffer[0], and set expected = 1. All other positions are ignored.
REQ-019 In CAPTURE, SHALL handle each arriving position as follows:
- position == expected: store the code, increment expected, clear the stall counter.
- position == expected-1: overwrite that buffer entry (held digit), no error.
- position 0: restart the capture at expected = 1.
- any other position: pulse err_seq and go to HUNT.
REQ-020 In CAPTURE, when position 11 is stored with expected == 11, SHALL go to EMIT on the next cycle.
REQ-021 In CAPTURE, when the stall counter reaches STALL_MAX, SHALL pulse err_seq, go to HUNT, and clear the counter. The counter saturates and never wraps.
REQ-022 When registered sel has more than one bit set, in any state other than EMIT, SHALL pulse err_sel and go to HUNT; the buffer is unchanged.
REQ-023 In EMIT, SHALL present buffer[k] on out_char with out_pos = k, starting at k = 0, with out_valid high.
REQ-024 In EMIT, SHALL advance k only on the cycle where out_valid && out_ready. out_char and out_pos SHALL stay stable while out_valid && !out_ready.
REQ-025 After position 11 transfers, SHALL deassert out_valid, pulse frame_done for one cycle, and go to HUNT.
REQ-026 During EMIT, SHALL ignore the scan inputs (no capture and no error pulses).
REQ-027 Outside EMIT, out_valid SHALL be 0.

Reset
REQ-028 With rst_n low at a rising edge, SHALL set:
- state = HUNT
- out_valid, frame_done and all err_* = 0
- out_char = 0, out_pos = 0
- buffer entries = 0, expected = 0, stall counter = 0
- input stage = 0.
REQ-029 Reset asserted mid-EMIT or mid-CAPTURE SHALL abandon the frame; out_valid SHALL be low on the cycle after the reset edge.

Configuration
REQ-030 With SCAN_DEC_GLYPH_ERR_EN defined, an unknown glyph accepted in HUNT or CAPTURE SHALL pulse err_glyph and send the block to HUNT, discarding the frame.
REQ-031 Without SCAN_DEC_GLYPH_ERR_EN, SHALL store an unknown glyph as code 6'h3F, continue the capture, and tie err_glyph to 0.

Structure
REQ-032 Package scan_dec_pkg SHALL hold NUM_DIGITS = 12, the 14-bit glyph pattern constants, the 6-bit code constants (including CODE_UNKNOWN = 6'h3F), and the state enum.
REQ-033 The glyph-to-code map SHALL be the combinational sub-module scan_glyph_lut (14-bit in, 6-bit code plus a known flag out).

Verification
REQ-034 Scenario 1: one clean scan of "LOS RIALES" + 2 spaces (one digit per cycle, out_ready = 1) -> out_char sequence 12,15,19,0,18,9,1,12,5,19,0,0 at out_pos 0..11, then frame_done for one cycle.
REQ-035 Scenario 2: the same scan with out_ready toggling 1,0,0,1,... -> no character lost or duplicated; out_char and out_pos stable while stalled.
REQ-036 Scenario 3: sel = 12'b000000000110 during CAPTURE -> err_sel pulse, state HUNT; a following full scan decodes correctly.
REQ-037 Scenario 4: positions 0,1,2,5 -> err_seq on the arrival of position 5; no frame emitted. Also: position 3 held for 17 cycles with STALL_MAX = 16 -> err_seq timeout.
REQ-038 Scenario 5: segm = 14'h3FFF at position 4 -> with the macro: err_glyph pulse and no frame; without the macro: a frame is emitted with out_char = 6'h3F at out_pos 4.
REQ-039 Scenario 6: rst_n low while out_pos = 6 in EMIT -> out_valid = 0 on the next cycle, all outputs at reset values, state HUNT.
